// File: rtl/l1_dcache_pkg.sv
// Shared types and helpers for the L1 data cache: FSM state encoding,
// line geometry and address field extraction for a given index width.
package dcache_types;

    localparam int LINE_W     = 256;
    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;
    localparam int LINE_BYTES = LINE_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        WRITEBACK,
        ALLOCATE
    } dcache_state_t;

    // Word within the line, addr[4:2].
    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] addr);
        return addr[4:2];
    endfunction

    // Set index, addr[4+s_index:5], returned zero-extended.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int s_index);
        return (addr >> OFFSET_W) & ((32'd1 << s_index) - 32'd1);
    endfunction

    // Tag, addr[31:5+s_index], returned zero-extended.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int s_index);
        return addr >> (OFFSET_W + s_index);
    endfunction

endpackage

// File: rtl/l1_dcache_array.sv
// Small register-file array: asynchronous read, synchronous write with
// per-byte write enables and a synchronous clear of every entry.
module dcache_array #(
    parameter int WIDTH  = 8,
    parameter int IDX_W  = 3,
    parameter int NBYTES = (WIDTH + 7) / 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [IDX_W-1:0]  raddr,
    output logic [WIDTH-1:0]  rdata,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [NBYTES-1:0] wbe,
    input  logic [WIDTH-1:0]  wdata
);

    localparam int DEPTH = 1 << IDX_W;

    logic [WIDTH-1:0] mem [DEPTH];

    // Combinational read so the lookup resolves in the request cycle.
    assign rdata = mem[raddr];

    // Clear has priority over a write landing in the same cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                if (wbe[b/8]) begin
                    mem[waddr][b] <= wdata[b];
                end
            end
        end
    end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// 32-bit CPU word port in front, single-beat 256-bit line port behind.
// Optional feature macro: DCACHE_PERF_CNT_EN enables saturating hit/miss
// counters; without it hit_count/miss_count are tied to zero.
module l1_dcache
    import dcache_types::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         data_read,
    input  logic         data_write,
    input  logic [3:0]   data_mbe,
    input  logic [31:0]  data_addr,
    input  logic [31:0]  data_wdata,
    output logic         data_resp,
    output logic [31:0]  data_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int TAG_W  = 27 - S_INDEX;
    localparam int TAG_NB = (TAG_W + 7) / 8;

    dcache_state_t state, next_state;

    logic [S_INDEX-1:0]    idx;
    logic [TAG_W-1:0]      tag;
    logic [WORD_SEL_W-1:0] word_sel;
    logic                  req;
    logic                  hit;

    logic [LINE_W-1:0]     line_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  valid_q;
    logic                  dirty_q;

    logic [LINE_BYTES-1:0] data_we;
    logic [LINE_W-1:0]     data_wd;
    logic                  tag_we;
    logic                  valid_we;
    logic                  valid_wd;
    logic                  dirty_we;
    logic                  dirty_wd;

    assign idx      = S_INDEX'(addr_index(data_addr, S_INDEX));
    assign tag      = TAG_W'(addr_tag(data_addr, S_INDEX));
    assign word_sel = addr_word(data_addr);
    assign req      = data_read | data_write;
    assign hit      = valid_q && (tag_q == tag);

    // NOTE: the line and tag arrays hold don't-care contents until valid is
    // set, so they get no clear; only valid and dirty need the reset network.
    dcache_array #(.WIDTH(LINE_W), .IDX_W(S_INDEX)) u_data (
        .clk   (clk),
        .clr   (1'b0),
        .raddr (idx),
        .rdata (line_q),
        .waddr (idx),
        .wbe   (data_we),
        .wdata (data_wd)
    );

    dcache_array #(.WIDTH(TAG_W), .IDX_W(S_INDEX)) u_tag (
        .clk   (clk),
        .clr   (1'b0),
        .raddr (idx),
        .rdata (tag_q),
        .waddr (idx),
        .wbe   ({TAG_NB{tag_we}}),
        .wdata (tag)
    );

    dcache_array #(.WIDTH(1), .IDX_W(S_INDEX)) u_valid (
        .clk   (clk),
        .clr   (rst),
        .raddr (idx),
        .rdata (valid_q),
        .waddr (idx),
        .wbe   (valid_we),
        .wdata (valid_wd)
    );

    dcache_array #(.WIDTH(1), .IDX_W(S_INDEX)) u_dirty (
        .clk   (clk),
        .clr   (rst),
        .raddr (idx),
        .rdata (dirty_q),
        .waddr (idx),
        .wbe   (dirty_we),
        .wdata (dirty_wd)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, array write controls and state-decoded outputs.
    // NOTE: every output of this block is defaulted first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state   = state;
        data_we      = '0;
        data_wd      = '0;
        tag_we       = 1'b0;
        valid_we     = 1'b0;
        valid_wd     = 1'b0;
        dirty_we     = 1'b0;
        dirty_wd     = 1'b0;
        data_resp    = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        next_state = RESP;
                        // A write wins when both read and write are raised.
                        if (data_write) begin
                            data_we  = LINE_BYTES'(data_mbe) << {word_sel, 2'b00};
                            data_wd  = {(LINE_W/32){data_wdata}};
                            dirty_we = 1'b1;
                            dirty_wd = 1'b1;
                        end
                    end else if (valid_q && dirty_q) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = ALLOCATE;
                    end
                end
            end

            RESP: begin
                data_resp  = 1'b1;
                next_state = IDLE;
            end

            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q, idx, 5'b0};
                pmem_wdata   = line_q;
                if (pmem_resp) begin
                    dirty_we   = 1'b1;
                    dirty_wd   = 1'b0;
                    next_state = ALLOCATE;
                end
            end

            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {data_addr[31:5], 5'b0};
                if (pmem_resp) begin
                    data_we    = '1;
                    data_wd    = pmem_rdata;
                    tag_we     = 1'b1;
                    valid_we   = 1'b1;
                    valid_wd   = 1'b1;
                    dirty_we   = 1'b1;
                    dirty_wd   = 1'b0;
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    // Capture the addressed word on a read hit; held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_rdata <= '0;
        end else if (state == IDLE && req && hit && !data_write) begin
            data_rdata <= line_q[{word_sel, 5'b0} +: 32];
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic recheck_q;
    logic count_hit;
    logic count_miss;

    assign count_hit  = (state == IDLE) && req && hit && !recheck_q;
    assign count_miss = (state == IDLE) && req && !hit;

    // Marks the IDLE lookup right after a fill so it is not counted as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            recheck_q <= 1'b0;
        end else if (state == ALLOCATE && pmem_resp) begin
            recheck_q <= 1'b1;
        end else if (state == IDLE) begin
            recheck_q <= 1'b0;
        end
    end

    // Saturating hit and miss counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (count_hit && hit_count != 32'hFFFF_FFFF) begin
                hit_count <= hit_count + 32'd1;
            end
            if (count_miss && miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Directed testbench for l1_dcache (S_INDEX = 3). The bench plays both the
// CPU and the memory side and carries its own expected lines and counters.
// Build with DCACHE_PERF_CNT_EN defined to expect live counters.
module tb_l1_dcache;

`ifdef DCACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         data_read = 1'b0;
    logic         data_write = 1'b0;
    logic [3:0]   data_mbe = '0;
    logic [31:0]  data_addr = '0;
    logic [31:0]  data_wdata = '0;
    logic         data_resp;
    logic [31:0]  data_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] wb_line;

    l1_dcache #(.S_INDEX(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_read    (data_read),
        .data_write   (data_write),
        .data_mbe     (data_mbe),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_resp    (data_resp),
        .data_rdata   (data_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] mbe);
        data_read  = rd;
        data_write = wr;
        data_addr  = addr;
        data_wdata = wd;
        data_mbe   = mbe;
    endtask

    // Cycles until data_resp (-1 on timeout); drops the request and lets
    // the FSM return to IDLE before returning.
    task automatic wait_resp(output int cycles, output logic [31:0] rd, output logic saw_pmem);
        bit found = 1'b0;
        cycles   = 0;
        rd       = '0;
        saw_pmem = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            cycles++;
            if (pmem_read || pmem_write) saw_pmem = 1'b1;
            if (data_resp) begin
                rd    = data_rdata;
                found = 1'b1;
            end
        end
        data_read  = 1'b0;
        data_write = 1'b0;
        if (!found) cycles = -1;
        tick();
    endtask

    // Cycles until a memory request appears (-1 on timeout).
    task automatic wait_pmem(output int cycles);
        bit found = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            cycles++;
            if (pmem_read || pmem_write) found = 1'b1;
        end
        if (!found) cycles = -1;
    endtask

    task automatic pulse_pmem(input logic [255:0] line);
        pmem_rdata = line;
        pmem_resp  = 1'b1;
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tests_run++; if (data_resp !== 1'b0) begin tests_failed++; $display("FAIL reset_data_resp: got %b want 0", data_resp); end
        tests_run++; if (pmem_read !== 1'b0) begin tests_failed++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
        tests_run++; if (pmem_write !== 1'b0) begin tests_failed++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
        tests_run++; if (data_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_data_rdata: got %h want 0", data_rdata); end
        tests_run++; if (pmem_address !== 32'h0) begin tests_failed++; $display("FAIL reset_pmem_address: got %h want 0", pmem_address); end
        tests_run++; if (pmem_wdata !== 256'h0) begin tests_failed++; $display("FAIL reset_pmem_wdata: got %h want 0", pmem_wdata); end
        tests_run++; if (hit_count !== 32'h0) begin tests_failed++; $display("FAIL reset_hit_count: got %0d want 0", hit_count); end
        tests_run++; if (miss_count !== 32'h0) begin tests_failed++; $display("FAIL reset_miss_count: got %0d want 0", miss_count); end
    endtask

    task automatic test_clean_miss();
        int c;
        logic [31:0] rd;
        logic saw;
        cpu_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
        wait_pmem(c);
        tests_run++; if (c !== 1) begin tests_failed++; $display("FAIL clean_miss_latency: got %0d want 1", c); end
        tests_run++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin tests_failed++; $display("FAIL clean_miss_cmd: got rd=%b wr=%b want rd=1 wr=0", pmem_read, pmem_write); end
        tests_run++; if (pmem_address !== 32'h0000_0040) begin tests_failed++; $display("FAIL clean_miss_addr: got %h want 00000040", pmem_address); end
        tick();
        tick();
        tests_run++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0040) begin tests_failed++; $display("FAIL clean_miss_held: got rd=%b addr=%h want rd=1 addr=00000040", pmem_read, pmem_address); end
        pulse_pmem(line_a);
        exp_misses++;
        wait_resp(c, rd, saw);
        tests_run++; if (c + 1 !== 2) begin tests_failed++; $display("FAIL fill_to_resp: got %0d want 2", c + 1); end
        tests_run++; if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL clean_miss_rdata: got %h want deadbeef", rd); end
        tests_run++; if (hit_count !== (PERF ? 32'(exp_hits) : 32'h0)) begin tests_failed++; $display("FAIL recheck_not_hit: got %0d want %0d", hit_count, PERF ? exp_hits : 0); end
        tests_run++; if (miss_count !== (PERF ? 32'(exp_misses) : 32'h0)) begin tests_failed++; $display("FAIL clean_miss_count: got %0d want %0d", miss_count, PERF ? exp_misses : 0); end
    endtask

    task automatic test_hit();
        int c;
        logic [31:0] rd;
        logic saw;
        cpu_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
        wait_resp(c, rd, saw);
        exp_hits++;
        tests_run++; if (c !== 1) begin tests_failed++; $display("FAIL hit_latency: got %0d want 1", c); end
        tests_run++; if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL hit_rdata_w0: got %h want deadbeef", rd); end
        tests_run++; if (saw !== 1'b0) begin tests_failed++; $display("FAIL hit_no_pmem: got %b want 0", saw); end
        cpu_req(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
        wait_resp(c, rd, saw);
        exp_hits++;
        tests_run++; if (rd !== 32'h5566_7788 || c !== 1) begin tests_failed++; $display("FAIL hit_rdata_w1: got %h in %0d want 55667788 in 1", rd, c); end
    endtask

    task automatic test_write_merge();
        int c;
        logic [31:0] rd;
        logic saw;
        cpu_req(1'b0, 1'b1, 32'h0000_0044, 32'h1122_3344, 4'b0101);
        wait_resp(c, rd, saw);
        exp_hits++;
        tests_run++; if (c !== 1) begin tests_failed++; $display("FAIL write_hit_latency: got %0d want 1", c); end
        cpu_req(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
        wait_resp(c, rd, saw);
        exp_hits++;
        tests_run++; if (rd !== 32'h5522_7744) begin tests_failed++; $display("FAIL write_merge_mbe5: got %h want 55227744", rd); end
        cpu_req(1'b0, 1'b1, 32'h0000_0048, 32'hFFFF_FFFF, 4'b0000);
        wait_resp(c, rd, saw);
        exp_hits++;
        tests_run++; if (c !== 1) begin tests_failed++; $display("FAIL write_mbe0_resp: got %0d want 1", c); end
        cpu_req(1'b1, 1'b0, 32'h0000_0048, 32'h0, 4'h0);
        wait_resp(c, rd, saw);
        exp_hits++;
        tests_run++; if (rd !== 32'h1000_0002) begin tests_failed++; $display("FAIL write_mbe0_nochange: got %h want 10000002", rd); end
        cpu_req(1'b1, 1'b1, 32'h0000_004C, 32'hCAFE_F00D, 4'b1111);
        wait_resp(c, rd, saw);
        exp_hits++;
        cpu_req(1'b1, 1'b0, 32'h0000_004C, 32'h0, 4'h0);
        wait_resp(c, rd, saw);
        exp_hits++;
        tests_run++; if (rd !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL read_write_as_write: got %h want cafef00d", rd); end
    endtask

    task automatic test_dirty_miss();
        int c;
        logic [31:0] rd;
        logic saw;
        cpu_req(1'b1, 1'b0, 32'h0000_0140, 32'h0, 4'h0);
        wait_pmem(c);
        tests_run++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin tests_failed++; $display("FAIL wb_cmd: got rd=%b wr=%b want rd=0 wr=1", pmem_read, pmem_write); end
        tests_run++; if (pmem_address !== 32'h0000_0040) begin tests_failed++; $display("FAIL wb_addr: got %h want 00000040", pmem_address); end
        tests_run++; if (pmem_wdata !== wb_line) begin tests_failed++; $display("FAIL wb_line: got %h want %h", pmem_wdata, wb_line); end
        pulse_pmem('0);
        tests_run++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin tests_failed++; $display("FAIL wb_then_fill_cmd: got rd=%b wr=%b want rd=1 wr=0", pmem_read, pmem_write); end
        tests_run++; if (pmem_address !== 32'h0000_0140) begin tests_failed++; $display("FAIL wb_then_fill_addr: got %h want 00000140", pmem_address); end
        pulse_pmem(line_b);
        exp_misses++;
        wait_resp(c, rd, saw);
        tests_run++; if (rd !== 32'hA5A5_0140) begin tests_failed++; $display("FAIL dirty_miss_rdata: got %h want a5a50140", rd); end
        tests_run++; if (hit_count !== (PERF ? 32'(exp_hits) : 32'h0)) begin tests_failed++; $display("FAIL hit_count_mid: got %0d want %0d", hit_count, PERF ? exp_hits : 0); end
        tests_run++; if (miss_count !== (PERF ? 32'(exp_misses) : 32'h0)) begin tests_failed++; $display("FAIL miss_count_mid: got %0d want %0d", miss_count, PERF ? exp_misses : 0); end
        // Leave this set dirty so the reset test can show dirty was cleared.
        cpu_req(1'b0, 1'b1, 32'h0000_0140, 32'h0102_0304, 4'b1111);
        wait_resp(c, rd, saw);
        exp_hits++;
    endtask

    task automatic test_reset_mid_miss();
        int c;
        logic [31:0] rd;
        logic saw;
        cpu_req(1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'h0);
        wait_pmem(c);
        tests_run++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0060) begin tests_failed++; $display("FAIL pre_reset_alloc: got rd=%b addr=%h want rd=1 addr=00000060", pmem_read, pmem_address); end
        rst = 1'b1;
        data_read = 1'b0;
        tick();
        rst = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        tests_run++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin tests_failed++; $display("FAIL reset_abandon: got rd=%b wr=%b want 0 0", pmem_read, pmem_write); end
        tests_run++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin tests_failed++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_count, miss_count); end
        pulse_pmem({8{32'hBAD0_BAD0}});
        tests_run++; if (data_resp !== 1'b0 || pmem_read !== 1'b0) begin tests_failed++; $display("FAIL late_resp_ignored: got resp=%b rd=%b want 0 0", data_resp, pmem_read); end
        tick();
        tests_run++; if (data_resp !== 1'b0) begin tests_failed++; $display("FAIL late_resp_quiet: got %b want 0", data_resp); end
        // Tag for 0x140 is still stored but valid and dirty were cleared.
        cpu_req(1'b1, 1'b0, 32'h0000_0140, 32'h0, 4'h0);
        wait_pmem(c);
        tests_run++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin tests_failed++; $display("FAIL post_reset_miss: got rd=%b wr=%b want rd=1 wr=0", pmem_read, pmem_write); end
        tests_run++; if (pmem_address !== 32'h0000_0140) begin tests_failed++; $display("FAIL post_reset_addr: got %h want 00000140", pmem_address); end
        pulse_pmem(line_b);
        exp_misses++;
        wait_resp(c, rd, saw);
        tests_run++; if (rd !== 32'hA5A5_0140) begin tests_failed++; $display("FAIL post_reset_rdata: got %h want a5a50140", rd); end
    endtask

    task automatic test_back_to_back();
        cpu_req(1'b1, 1'b0, 32'h0000_0140, 32'h0, 4'h0);
        tick();
        tests_run++; if (data_resp !== 1'b1 || data_rdata !== 32'hA5A5_0140) begin tests_failed++; $display("FAIL b2b_first: got resp=%b data=%h want 1 a5a50140", data_resp, data_rdata); end
        data_addr = 32'h0000_0144;
        tick();
        tests_run++; if (data_resp !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap: got %b want 0", data_resp); end
        tick();
        tests_run++; if (data_resp !== 1'b1 || data_rdata !== 32'hB000_0001) begin tests_failed++; $display("FAIL b2b_second: got resp=%b data=%h want 1 b0000001", data_resp, data_rdata); end
        data_read = 1'b0;
        tick();
        exp_hits += 2;
        tests_run++; if (hit_count !== (PERF ? 32'(exp_hits) : 32'h0)) begin tests_failed++; $display("FAIL hit_count_final: got %0d want %0d", hit_count, PERF ? exp_hits : 0); end
        tests_run++; if (miss_count !== (PERF ? 32'(exp_misses) : 32'h0)) begin tests_failed++; $display("FAIL miss_count_final: got %0d want %0d", miss_count, PERF ? exp_misses : 0); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            line_a[i*32 +: 32] = 32'h1000_0000 + 32'(i);
            line_b[i*32 +: 32] = 32'hB000_0000 + 32'(i);
        end
        line_a[31:0]  = 32'hDEAD_BEEF;
        line_a[63:32] = 32'h5566_7788;
        line_b[31:0]  = 32'hA5A5_0140;
        wb_line          = line_a;
        wb_line[63:32]   = 32'h5522_7744;
        wb_line[127:96]  = 32'hCAFE_F00D;

        test_reset();
        test_clean_miss();
        test_hit();
        test_write_merge();
        test_dirty_miss();
        test_reset_mid_miss();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
